// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared definitions for the mult arbiter slice
// Build option: MULT_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
package mult_arb_pkg;

    // Default configuration: two requesters sharing one 8x8 multiplier.
    localparam int MULT_ARB_N_REQ = 2;
    localparam int MULT_ARB_OP_W  = 8;

    // Controller state encoding.
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ISSUE  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_ISSUE  = ISSUE,
        ST_SETTLE = SETTLE,
        ST_WAIT   = WAIT,
        ST_DONE   = DONE
    } arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int arb_idx_w(input int n_req);
        return (n_req > 2) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker for the mult arbiter
// Build option: MULT_ARB_FIXED_PRIO_EN ties the pointer to 0 (plain lowest-index priority encoder).
// Ports:
//   i_req  in   N_REQ  request vector
//   i_ptr  in   IDX_W  index that has highest priority this round
//   o_gnt  out  N_REQ  one-hot winner (zero when no request)
//   o_idx  out  IDX_W  binary winner index
//   o_any  out  1      at least one request present
module rr_pick
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = MULT_ARB_N_REQ,
    parameter int IDX_W = arb_idx_w(MULT_ARB_N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_ptr;

`ifdef MULT_ARB_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;
    assign w_ptr        = '0;
`else
    assign w_ptr = i_ptr;
`endif

    // Scan offsets 0..N_REQ-1 from the pointer; the first set bit wins.
    // The pointer is always < N_REQ, so a single subtraction wraps the sum.
    always_comb begin
        logic [IDX_W:0]   v_sum;
        logic [IDX_W-1:0] v_j;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        v_sum = '0;
        v_j   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_sum = {1'b0, w_ptr} + (IDX_W+1)'(k);
            if (v_sum >= (IDX_W+1)'(N_REQ)) begin
                v_sum = v_sum - (IDX_W+1)'(N_REQ);
            end
            v_j = v_sum[IDX_W-1:0];
            if (!o_any && i_req[v_j]) begin
                o_any      = 1'b1;
                o_gnt[v_j] = 1'b1;
                o_idx      = v_j;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - shares one mult instance between N_REQ sequencing datapaths
// Build option: MULT_ARB_FIXED_PRIO_EN -> fixed lowest-index priority, no round-robin pointer.
// Ports:
//   clk_i         in   1           clock, rising edge
//   rst_i         in   1           synchronous reset, active low
//   req_i         in   N_REQ       per-requester level request
//   a_i, b_i      in   N_REQ*OP_W  packed operands, slice k for requester k
//   gnt_o         out  N_REQ       one-hot grant, held for the whole transaction
//   done_o        out  N_REQ       one-hot one-cycle pulse when y_o is valid
//   y_o           out  2*OP_W      last captured product
//   busy_o        out  1           controller not idle
//   mult_a_o/b_o  out  OP_W        operands to the shared mult
//   mult_start_o  out  1           one-cycle start to the shared mult
//   mult_busy_i   in   1           busy from the shared mult
//   mult_y_i      in   2*OP_W      product from the shared mult
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = MULT_ARB_N_REQ,
    parameter int OP_W  = MULT_ARB_OP_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [N_REQ*OP_W-1:0] a_i,
    input  logic [N_REQ*OP_W-1:0] b_i,
    output logic [N_REQ-1:0]      gnt_o,
    output logic [N_REQ-1:0]      done_o,
    output logic [2*OP_W-1:0]     y_o,
    output logic                  busy_o,
    output logic [OP_W-1:0]       mult_a_o,
    output logic [OP_W-1:0]       mult_b_o,
    output logic                  mult_start_o,
    input  logic                  mult_busy_i,
    input  logic [2*OP_W-1:0]     mult_y_i
);

    localparam int IDX_W = arb_idx_w(N_REQ);

    arb_state_t          r_state, w_state_nxt;
    logic [N_REQ-1:0]    r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0]    r_done, w_done_nxt;
    logic [2*OP_W-1:0]   r_y, w_y_nxt;
    logic [OP_W-1:0]     r_a, w_a_nxt;
    logic [OP_W-1:0]     r_b, w_b_nxt;
    logic                r_start, w_start_nxt;

    logic [IDX_W-1:0]    w_ptr;
    logic [N_REQ-1:0]    w_pick_gnt;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_any;
    logic [OP_W-1:0]     w_a_sel;
    logic [OP_W-1:0]     w_b_sel;

`ifdef MULT_ARB_FIXED_PRIO_EN
    logic w_unused_idx;
    assign w_unused_idx = ^w_pick_idx;
    assign w_ptr        = '0;
`else
    // Round-robin pointer and the index of the requester being served.
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    assign w_ptr = r_ptr;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req (req_i),
        .i_ptr (w_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Operand mux driven by the one-hot pick.
    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_pick_gnt[k]) begin
                w_a_sel = a_i[k*OP_W +: OP_W];
                w_b_sel = b_i[k*OP_W +: OP_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_y     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_start <= 1'b0;
`ifndef MULT_ARB_FIXED_PRIO_EN
            r_ptr   <= '0;
            r_idx   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_y     <= w_y_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_start <= w_start_nxt;
`ifndef MULT_ARB_FIXED_PRIO_EN
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
`endif
        end
    end

    // Outputs are registered on the transition into the state that owns them,
    // so start is high in ISSUE and done is high in DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_y_nxt     = r_y;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_start_nxt = 1'b0;
`ifndef MULT_ARB_FIXED_PRIO_EN
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_idx;
`endif
        case (r_state)
            ST_IDLE: begin
                // mult_busy_i is deliberately not looked at here.
                if (w_pick_any) begin
                    w_a_nxt     = w_a_sel;
                    w_b_nxt     = w_b_sel;
                    w_gnt_nxt   = w_pick_gnt;
                    w_start_nxt = 1'b1;
                    w_state_nxt = ST_ISSUE;
`ifndef MULT_ARB_FIXED_PRIO_EN
                    w_idx_nxt   = w_pick_idx;
`endif
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                // mult raises busy one cycle after start; skip that cycle.
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!mult_busy_i) begin
                    w_y_nxt     = mult_y_i;
                    w_done_nxt  = r_gnt;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
`ifndef MULT_ARB_FIXED_PRIO_EN
                w_ptr_nxt   = (r_idx == IDX_W'(N_REQ-1)) ? '0 : r_idx + 1'b1;
`endif
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign gnt_o        = r_gnt;
    assign done_o       = r_done;
    assign y_o          = r_y;
    assign busy_o       = (r_state != ST_IDLE);
    assign mult_a_o     = r_a;
    assign mult_b_o     = r_b;
    assign mult_start_o = r_start;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench for mult_arbiter (honours MULT_ARB_FIXED_PRIO_EN)
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [1:0]  req_i = 2'b00;
    logic [7:0]  ta0 = 8'd0, tb0 = 8'd0, ta1 = 8'd0, tb1 = 8'd0;
    logic [15:0] a_i, b_i;
    logic [1:0]  gnt_o, done_o;
    logic [15:0] y_o;
    logic        busy_o;
    logic [7:0]  mult_a_o, mult_b_o;
    logic        mult_start_o;
    logic        mult_busy_i;
    logic [15:0] mult_y_i;

    int total = 0;
    int bad   = 0;
    int mon_viol = 0;

    assign a_i = {ta1, ta0};
    assign b_i = {tb1, tb0};

    always #5 clk = ~clk;

    mult_arbiter #(.N_REQ(2), .OP_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .gnt_o        (gnt_o),
        .done_o       (done_o),
        .y_o          (y_o),
        .busy_o       (busy_o),
        .mult_a_o     (mult_a_o),
        .mult_b_o     (mult_b_o),
        .mult_start_o (mult_start_o),
        .mult_busy_i  (mult_busy_i),
        .mult_y_i     (mult_y_i)
    );

    // Behavioural mult: busy rises one cycle after start, stays high bm_len
    // cycles, product appears when busy falls (output is 0 while working).
    int          bm_len = 4;
    logic        m_pend = 1'b0;
    logic        m_busy = 1'b0;
    int          m_cnt  = 0;
    logic [7:0]  m_a = 8'd0, m_b = 8'd0;
    logic [15:0] m_y = 16'd0;

    always @(posedge clk) begin
        if (mult_start_o) begin
            m_a    <= mult_a_o;
            m_b    <= mult_b_o;
            m_pend <= 1'b1;
            m_y    <= 16'd0;
        end else if (m_pend) begin
            m_pend <= 1'b0;
            if (bm_len == 0) begin
                m_y <= 16'(m_a) * 16'(m_b);
            end else begin
                m_busy <= 1'b1;
                m_cnt  <= bm_len;
            end
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_y    <= 16'(m_a) * 16'(m_b);
            end
            m_cnt <= m_cnt - 1;
        end
    end

    assign mult_busy_i = m_busy;
    assign mult_y_i    = m_y;

    // Grant/done must never be multi-hot, and done only for the granted requester.
    always @(negedge clk) begin
        if (!$onehot0(done_o) || !$onehot0(gnt_o) || ((done_o & ~gnt_o) != 2'b00)) begin
            mon_viol++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered and left at the falling edge of an IDLE cycle.
    task automatic run_txn(input string tag, input logic [1:0] req,
                           input logic [7:0] a0, input logic [7:0] b0,
                           input logic [7:0] a1, input logic [7:0] b1,
                           input int len, input int eidx, input logic [15:0] ey,
                           input bit drop);
        int         lat;
        int         starts;
        logic [1:0] exp_oh;
        exp_oh = (eidx == 0) ? 2'b01 : 2'b10;
        req_i  = req;
        ta0 = a0; tb0 = b0; ta1 = a1; tb1 = b1;
        bm_len = len;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".gnt"}, 32'(gnt_o), 32'(exp_oh));
        chk({tag, ".busy"}, 32'(busy_o), 32'd1);
        chk({tag, ".mult_a"}, 32'(mult_a_o), 32'((eidx == 0) ? a0 : a1));
        chk({tag, ".mult_b"}, 32'(mult_b_o), 32'((eidx == 0) ? b0 : b1));
        starts = mult_start_o ? 1 : 0;
        if (drop) begin
            req_i = 2'b00;
            ta0 = 8'd77; tb0 = 8'd77; ta1 = 8'd1; tb1 = 8'd99;
        end
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (mult_start_o) starts++;
            if (done_o != 2'b00) break;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(3 + len));
        chk({tag, ".done"}, 32'(done_o), 32'(exp_oh));
        chk({tag, ".y"}, 32'(y_o), 32'(ey));
        chk({tag, ".starts"}, 32'(starts), 32'd1);
        chk({tag, ".gnt_in_done"}, 32'(gnt_o), 32'(exp_oh));
        req_i = 2'b00;
        @(negedge clk);
        chk({tag, ".idle_after"}, 32'({busy_o, gnt_o, done_o}), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [7:0]  a0, b0, a1, b1;
        int          len;
        int          idx_rr, idx_fp;
        logic [15:0] y_rr, y_fp;
    } vec_t;

    vec_t vt[9];

    initial begin
        int          seen;
        int          eidx;
        logic [15:0] ey;

        //           req    a0      b0      a1       b1    len rr fp  y_rr      y_fp
        vt[0] = '{2'b01, 8'd3,   8'd5,   8'd0,   8'd0,   4, 0, 0, 16'd15,    16'd15};
        vt[1] = '{2'b10, 8'd0,   8'd0,   8'd4,   8'd6,   0, 1, 1, 16'd24,    16'd24};
        vt[2] = '{2'b11, 8'd2,   8'd7,   8'd9,   8'd9,   4, 0, 0, 16'd14,    16'd14};
        vt[3] = '{2'b11, 8'd2,   8'd7,   8'd9,   8'd9,   4, 1, 0, 16'd81,    16'd14};
        vt[4] = '{2'b11, 8'd2,   8'd7,   8'd9,   8'd9,   4, 0, 0, 16'd14,    16'd14};
        vt[5] = '{2'b11, 8'd2,   8'd7,   8'd9,   8'd9,   4, 1, 0, 16'd81,    16'd14};
        vt[6] = '{2'b01, 8'd255, 8'd255, 8'd0,   8'd0,   4, 0, 0, 16'hFE01,  16'hFE01};
        vt[7] = '{2'b01, 8'd0,   8'd200, 8'd0,   8'd0,   2, 0, 0, 16'd0,     16'd0};
        vt[8] = '{2'b10, 8'd0,   8'd0,   8'd128, 8'd2,   1, 1, 1, 16'd256,   16'd256};

        rst_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.gnt", 32'(gnt_o), 32'd0);
        chk("reset.done", 32'(done_o), 32'd0);
        chk("reset.y", 32'(y_o), 32'd0);
        chk("reset.busy", 32'(busy_o), 32'd0);
        chk("reset.start", 32'(mult_start_o), 32'd0);
        chk("reset.ab", 32'({mult_a_o, mult_b_o}), 32'd0);
        rst_i = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
            eidx = vt[i].idx_fp;
            ey   = vt[i].y_fp;
`else
            eidx = vt[i].idx_rr;
            ey   = vt[i].y_rr;
`endif
            run_txn($sformatf("vec%0d", i), vt[i].req, vt[i].a0, vt[i].b0,
                    vt[i].a1, vt[i].b1, vt[i].len, eidx, ey, 1'b0);
        end

        // Requester 1 drops its request and changes operands mid-transaction.
        run_txn("drop", 2'b10, 8'd0, 8'd0, 8'd4, 8'd6, 4, 1, 16'd24, 1'b1);

        // Serve requester 0 so the round-robin pointer moves to 1.
        run_txn("pre_rst", 2'b01, 8'd7, 8'd3, 8'd0, 8'd0, 0, 0, 16'd21, 1'b0);

        // Reset in the middle of WAIT.
        req_i = 2'b10; ta1 = 8'd11; tb1 = 8'd11; bm_len = 4;
        @(posedge clk);
        @(negedge clk);
        chk("rst_seq.gnt", 32'(gnt_o), 32'd2);
        req_i = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_seq.in_wait", 32'({busy_o, done_o}), 32'h4);
        rst_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        chk("rst_seq.gnt0", 32'(gnt_o), 32'd0);
        chk("rst_seq.done0", 32'(done_o), 32'd0);
        chk("rst_seq.y0", 32'(y_o), 32'd0);
        chk("rst_seq.busy0", 32'(busy_o), 32'd0);
        chk("rst_seq.ab0", 32'({mult_start_o, mult_a_o, mult_b_o}), 32'd0);

        // The abandoned mult keeps running; nothing must be reported.
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done_o != 2'b00 || busy_o || gnt_o != 2'b00) seen++;
        end
        chk("rst_seq.no_report", 32'(seen), 32'd0);
        chk("rst_seq.y_held0", 32'(y_o), 32'd0);

        // Pointer is back at 0: requester 0 wins a simultaneous request.
        run_txn("post_rst_both", 2'b11, 8'd6, 8'd6, 8'd9, 8'd9, 4, 0, 16'd36, 1'b0);
        run_txn("post_rst_r1", 2'b10, 8'd0, 8'd0, 8'd5, 8'd5, 0, 1, 16'd25, 1'b0);

        chk("onehot_monitor", 32'(mon_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
